// File: rtl/lfsr_stream.sv
// lfsr_stream: Fibonacci LFSR emitting W bits per cycle as a valid/ready word stream
//   Optional recovery from the all-zero state: define LFSR_LOCKUP_RECOVER_EN
//   clk_i        rising-edge clock
//   reset_i      synchronous active-high reset
//   enable_i     permits generation of new words
//   seed_load_i  loads seed_i into the state, discards any pending word
//   seed_i       N-bit seed
//   m_valid_o    m_data_o holds a valid word
//   m_ready_i    consumer accepts the word
//   m_data_o     W-bit word, bit 0 generated first
//   word_cnt_o   accepted-word count, wraps
//   lockup_o     state is all-zero
module lfsr_stream #(
    parameter int N = 8,
    parameter int W = 1,
    parameter logic [N-1:0] START_VALUE = {{(N-1){1'b0}}, 1'b1},
    parameter logic [N-1:0] TAPS = {{(N-2){1'b0}}, 2'b11},
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             seed_load_i,
    input  logic [N-1:0]     seed_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [W-1:0]     m_data_o,
    output logic [CNT_W-1:0] word_cnt_o,
    output logic             lockup_o
);
    logic [N-1:0] state;
    logic [N-1:0] state_next;
    logic [W-1:0] word;
    logic         gen;
    logic         hs;

    // W chained steps: each emits the MSB, then shifts in the tap parity
    always_comb begin
        state_next = state;
        word = '0;
        for (int k = 0; k < W; k++) begin
            word[k] = state_next[N-1];
            state_next = {state_next[N-2:0], ^(state_next & TAPS)};
        end
    end

    assign hs  = m_valid_o & m_ready_i;
    assign gen = enable_i & ~seed_load_i & (~m_valid_o | m_ready_i);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= START_VALUE;
            m_valid_o  <= 1'b0;
            m_data_o   <= '0;
            word_cnt_o <= '0;
            lockup_o   <= (START_VALUE == '0);
        end else if (seed_load_i) begin
            // the same-cycle handshake is dropped along with the word
            state     <= seed_i;
            m_valid_o <= 1'b0;
            lockup_o  <= (seed_i == '0);
`ifdef LFSR_LOCKUP_RECOVER_EN
        end else if (state == '0) begin
            // recovery cycle: reload instead of stepping, no new word
            state      <= START_VALUE;
            m_valid_o  <= m_valid_o & ~m_ready_i;
            word_cnt_o <= word_cnt_o + CNT_W'(hs);
            lockup_o   <= (START_VALUE == '0);
`endif
        end else begin
            word_cnt_o <= word_cnt_o + CNT_W'(hs);
            if (gen) begin
                m_data_o  <= word;
                state     <= state_next;
                m_valid_o <= 1'b1;
                lockup_o  <= (state_next == '0);
            end else if (hs) begin
                m_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lfsr_stream.sv
// tb_lfsr_stream: directed and randomized checks of lfsr_stream against a behavioural model
module tb_lfsr_stream;
    logic       clk = 1'b0;
    logic       rst_a = 1'b1, en_a = 1'b0, load_a = 1'b0, rdy_a = 1'b0;
    logic [3:0] seed_a = '0;
    logic       valid_a, lock_a;
    logic [3:0] data_a;
    logic [3:0] cnt_a;

    logic        rst_b = 1'b1, en_b = 1'b0, rdy_b = 1'b0;
    logic        valid_b, lock_b;
    logic [0:0]  data_b;
    logic [31:0] cnt_b;
    logic [7:0]  seed_b = '0;

    int errors = 0;
    int checks = 0;
    bit chk_on = 0;
    bit b_done = 0;

    always #5 clk = ~clk;

    lfsr_stream #(.N(4), .W(4), .START_VALUE(4'b0001), .TAPS(4'b0011), .CNT_W(4)) dut_a (
        .clk_i(clk), .reset_i(rst_a), .enable_i(en_a), .seed_load_i(load_a), .seed_i(seed_a),
        .m_valid_o(valid_a), .m_ready_i(rdy_a), .m_data_o(data_a), .word_cnt_o(cnt_a), .lockup_o(lock_a));

    lfsr_stream dut_b (
        .clk_i(clk), .reset_i(rst_b), .enable_i(en_b), .seed_load_i(1'b0), .seed_i(seed_b),
        .m_valid_o(valid_b), .m_ready_i(rdy_b), .m_data_o(data_b), .word_cnt_o(cnt_b), .lockup_o(lock_b));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // software LFSR: produce W bits one at a time from an integer state
    task automatic model_gen(input int s, input int n, input int taps, input int w,
                             output int ns, output int word);
        word = 0;
        for (int k = 0; k < w; k++) begin
            word |= ((s >> (n - 1)) & 1) << k;
            s = ((s << 1) | ($countones(s & taps) & 1)) & ((1 << n) - 1);
        end
        ns = s;
    endtask

    // stream-level model of instance A
    int m_st, m_data, m_cnt;
    bit m_valid, m_lock;
    always @(posedge clk) begin
        bit hs;
        int ns, w;
        hs = m_valid && rdy_a;
        if (rst_a) begin
            m_st = 1; m_valid = 0; m_data = 0; m_cnt = 0;
        end else if (load_a) begin
            m_st = int'(seed_a); m_valid = 0;
`ifdef LFSR_LOCKUP_RECOVER_EN
        end else if (m_st == 0) begin
            m_st = 1;
            if (hs) begin m_cnt = (m_cnt + 1) % 16; m_valid = 0; end
`endif
        end else begin
            if (hs) m_cnt = (m_cnt + 1) % 16;
            if (en_a && (!m_valid || rdy_a)) begin
                model_gen(m_st, 4, 3, 4, ns, w);
                m_st = ns; m_data = w; m_valid = 1;
            end else if (hs) m_valid = 0;
        end
        m_lock = (m_st == 0);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("valid", valid_a, m_valid);
            chk("cnt", cnt_a, m_cnt);
            chk("lockup", lock_a, m_lock);
            if (m_valid) chk("data", data_a, m_data);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // serial 8-bit instance: 300 bits against the software step function
    initial begin
        int sb, ns, w;
        sb = 1;
        repeat (2) @(negedge clk);
        rst_b = 0; en_b = 1; rdy_b = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            chk("b_valid", valid_b, 1);
            model_gen(sb, 8, 3, 1, ns, w);
            chk("b_bit", data_b, w);
            sb = ns;
        end
        en_b = 0;
        @(negedge clk);
        chk("b_cnt", cnt_b, 300);
        chk("b_valid_off", valid_b, 0);
        b_done = 1;
    end

    initial begin
        int c0;
        step();
        chk_on = 1;
        step();
        chk("rst_valid", valid_a, 0);
        chk("rst_cnt", cnt_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_lock", lock_a, 0);
        // full throughput
        rst_a = 0; en_a = 1; rdy_a = 1;
        step(); chk("t1_w0", data_a, 4'h8); chk("t1_v", valid_a, 1); chk("t1_c0", cnt_a, 0);
        step(); chk("t1_w1", data_a, 4'hD); chk("t1_c1", cnt_a, 1);
        step(); chk("t1_c2", cnt_a, 2);
        // backpressure holds the word
        rst_a = 1; step();
        rst_a = 0; rdy_a = 0;
        step(); chk("t2_w", data_a, 4'h8); chk("t2_c", cnt_a, 0);
        repeat (5) begin
            step(); chk("t2_hold", data_a, 4'h8); chk("t2_hv", valid_a, 1); chk("t2_hc", cnt_a, 0);
        end
        rdy_a = 1;
        step(); chk("t2_next", data_a, 4'hD); chk("t2_c1", cnt_a, 1);
        // seed load beats a same-cycle handshake
        rdy_a = 0;
        step(); chk("t4_pend", valid_a, 1);
        c0 = int'(cnt_a);
        rdy_a = 1; load_a = 1; seed_a = 4'b0001;
        step(); chk("t4_v", valid_a, 0); chk("t4_c", cnt_a, c0);
        load_a = 0;
        step(); chk("t4_w", data_a, 4'h8); chk("t4_v1", valid_a, 1);
        // zero seed
        load_a = 1; seed_a = 4'h0;
        step(); chk("t5_lock", lock_a, 1); chk("t5_v", valid_a, 0);
        load_a = 0;
`ifdef LFSR_LOCKUP_RECOVER_EN
        step(); chk("t5_rlock", lock_a, 0); chk("t5_rv", valid_a, 0);
        step(); chk("t5_rw", data_a, 4'h8); chk("t5_rv1", valid_a, 1);
`else
        step(); chk("t5_w0", data_a, 0); chk("t5_l0", lock_a, 1); chk("t5_v0", valid_a, 1);
        step(); chk("t5_w1", data_a, 0); chk("t5_l1", lock_a, 1);
`endif
        // reset during a stall, then enable drop mid-stream
        rdy_a = 0;
        step(); step(); chk("t6_pend", valid_a, 1);
        rst_a = 1;
        step(); chk("t6_v", valid_a, 0); chk("t6_c", cnt_a, 0); chk("t6_l", lock_a, 0);
        rst_a = 0;
        step(); chk("t6_w", data_a, 4'h8);
        en_a = 0;
        repeat (3) begin
            step(); chk("t6_hv", valid_a, 1); chk("t6_hw", data_a, 4'h8);
        end
        rdy_a = 1;
        step(); chk("t6_acc_v", valid_a, 0); chk("t6_acc_c", cnt_a, 1);
        step(); chk("t6_idle", valid_a, 0);
        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            en_a   = ($urandom % 4) != 0;
            rdy_a  = ($urandom % 3) != 0;
            load_a = ($urandom % 20) == 0;
            seed_a = (($urandom % 3) == 0) ? 4'h0 : 4'($urandom);
            rst_a  = ($urandom % 100) == 0;
            step();
        end
        chk("b_done", b_done, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
